// File: rtl/fc_act_loader.sv
`default_nettype none
// ============================================================================
// Module   : fc_act_loader
// Purpose  : Stream-to-parallel activation loader for the FC neuron layers.
//            Collects WIDTH-bit activations one per valid/ready beat into an
//            IN-entry vector and holds it with x_valid until x_ack.
// Revision : 1.0 - initial release
// ============================================================================
module fc_act_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ack,
    output logic             err_len
);

    localparam int               IDX_W    = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             err_q,   err_d;
    // Goes high on the first clock after reset release so s_ready stays low
    // throughout reset even though the state already reads FILL.
    logic             live_q,  live_d;

    // Entry buffer already gated by its written-mask: an entry holds its
    // activation once written in the current vector and zero otherwise, so
    // the outputs come straight from flops with no gating logic after them.
    // Clearing the mask on ack is therefore a clear of this register.
    logic [WIDTH-1:0] x_q [0:IN-1];
    logic [WIDTH-1:0] x_d [0:IN-1];

    // Next-state, buffer update and handshake outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        err_d   = 1'b0;
        live_d  = 1'b1;
        s_ready = 1'b0;
        x_valid = 1'b0;

        unique case (state_q)
            FILL: begin
                s_ready = live_q;
                if (s_valid && live_q) begin
                    x_d[idx_q] = s_data;
                    if (idx_q == IDX_LAST) begin
                        // Vector full; flag a missing last marker.
                        state_d = HOLD;
                        idx_d   = '0;
                        err_d   = ~s_last;
                    end else if (s_last) begin
                        // Early last: remaining entries stay zero.
                        state_d = HOLD;
                        idx_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            HOLD: begin
                x_valid = 1'b1;
                if (x_ack) begin
                    state_d = FILL;
                    idx_d   = '0;
                    for (int i = 0; i < IN; i++) begin
                        x_d[i] = '0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, index, pulse and buffer registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            live_q  <= live_d;
            for (int i = 0; i < IN; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign err_len = err_q;

    generate
        for (genvar gi = 0; gi < IN; gi++) begin : g_x
            assign x[gi] = x_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fc_act_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_act_loader
// Purpose  : Self-checking bench for fc_act_loader; vectors are modelled as
//            plain arrays of accepted beats, zero beyond the last beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_act_loader;

    localparam int WIDTH = 8;
    localparam int IN    = 128;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ack;
    logic             err_len;

    logic [WIDTH-1:0] exp_x [0:IN-1];
    int               n_checks;
    int               n_pass;

    fc_act_loader #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .x       (x),
        .x_valid (x_valid),
        .x_ack   (x_ack),
        .err_len (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic clear_model();
        for (int i = 0; i < IN; i++) exp_x[i] = '0;
    endtask

    task automatic check_x(input string tag);
        for (int i = 0; i < IN; i++) chk($sformatf("%s_x%0d", tag, i), 64'(x[i]), 64'(exp_x[i]));
    endtask

    // Send one vector. last_at<0 means s_last is never set. dmode: 0=index,
    // 1=fixed value, 2=random. from_hold: the loader is in HOLD with x_ack=1.
    task automatic send_vector(input string tag, input int last_at, input int dmode,
                               input logic [WIDTH-1:0] fixed, input int gap_pct,
                               input bit from_hold);
        int               final_pos;
        int               j;
        int               cyc;
        logic             v;
        logic             exp_rdy;
        logic             exp_err;
        logic [WIDTH-1:0] d;
        final_pos = (last_at >= 0 && last_at < IN) ? last_at : IN - 1;
        exp_err   = (last_at != IN - 1);
        clear_model();
        j   = 0;
        cyc = 0;
        while (j <= final_pos && cyc < 4000) begin
            v = ($urandom_range(99) >= gap_pct);
            d = (dmode == 0) ? WIDTH'(j) : (dmode == 1) ? fixed : WIDTH'($urandom);
            s_valid = v;
            s_data  = v ? d : WIDTH'($urandom);
            s_last  = v ? (j == last_at) : 1'($urandom);
            exp_rdy = !(from_hold && cyc == 0);
            chk({tag, "_s_ready"}, 64'(s_ready), 64'(exp_rdy));
            @(posedge clk); #1;
            cyc++;
            if (v && exp_rdy) begin
                exp_x[j] = d;
                j++;
            end
            if (j <= final_pos) begin
                chk({tag, "_fill_x_valid"}, 64'(x_valid), 64'd0);
                chk({tag, "_fill_err_len"}, 64'(err_len), 64'd0);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk({tag, "_beats_done"}, 64'(j), 64'(final_pos + 1));
        chk({tag, "_x_valid"}, 64'(x_valid), 64'd1);
        chk({tag, "_err_len"}, 64'(err_len), 64'(exp_err));
        chk({tag, "_s_ready_hold"}, 64'(s_ready), 64'd0);
        check_x(tag);
    endtask

    task automatic do_ack(input string tag);
        x_ack = 1'b1;
        @(posedge clk); #1;
        x_ack = 1'b0;
        chk({tag, "_ack_s_ready"}, 64'(s_ready), 64'd1);
        chk({tag, "_ack_x_valid"}, 64'(x_valid), 64'd0);
        chk({tag, "_ack_err_len"}, 64'(err_len), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        x_ack    = 1'b0;

        // Reset state
        #1;
        chk("rst_x_valid", 64'(x_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        clear_model();
        check_x("rst");
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_s_ready", 64'(s_ready), 64'd1);
        chk("rel_x_valid", 64'(x_valid), 64'd0);

        // 1: full vector of index values, last on beat 127
        send_vector("t1", IN - 1, 0, '0, 0, 1'b0);

        // 2: stall in HOLD with upstream pushing, then ack
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'($urandom);
            s_last  = 1'($urandom);
            @(posedge clk); #1;
            chk("t2_s_ready", 64'(s_ready), 64'd0);
            chk("t2_x_valid", 64'(x_valid), 64'd1);
            chk("t2_err_len", 64'(err_len), 64'd0);
        end
        check_x("t2_frozen");
        s_valid = 1'b0;
        s_last  = 1'b0;
        do_ack("t2");
        clear_model();
        check_x("t2_cleared");

        // 3: early last after 5 beats of 0x7F
        send_vector("t3", 4, 1, 8'h7F, 0, 1'b0);
        @(posedge clk); #1;
        chk("t3_err_once", 64'(err_len), 64'd0);
        do_ack("t3");

        // 4: late last, s_last never set
        send_vector("t4", -1, 2, '0, 10, 1'b0);
        @(posedge clk); #1;
        chk("t4_err_once", 64'(err_len), 64'd0);
        do_ack("t4");

        // 5: back-to-back with x_ack tied high and random gaps
        x_ack = 1'b1;
        send_vector("t5a", IN - 1, 2, '0, 30, 1'b0);
        send_vector("t5b", int'($urandom_range(100, 10)), 2, '0, 30, 1'b1);
        send_vector("t5c", int'($urandom_range(9, 0)), 2, '0, 30, 1'b1);
        @(posedge clk); #1;
        x_ack = 1'b0;
        chk("t5_end_x_valid", 64'(x_valid), 64'd0);
        chk("t5_end_s_ready", 64'(s_ready), 64'd1);

        // 6: reset in the middle of a fill, then refill from entry 0
        for (int b = 0; b < 60; b++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'($urandom) | 8'h01;
            s_last  = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("t6_rst_x_valid", 64'(x_valid), 64'd0);
        chk("t6_rst_s_ready", 64'(s_ready), 64'd0);
        clear_model();
        check_x("t6_rst");
        @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_rel_s_ready", 64'(s_ready), 64'd1);
        send_vector("t6", IN - 1, 2, '0, 20, 1'b0);
        do_ack("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
